// File: rtl/niosii_system_data_format_adapter_pack2.sv
// Multi-channel Avalon-ST width adapter: packs pairs of SYMBOL_W input symbols
// into 2-symbol output beats. Each channel's half-built word lives in an
// external state RAM. The block reads the state, merges the new symbol and
// writes the state back. A small output FIFO absorbs sink backpressure.
module niosii_system_data_format_adapter_pack2 #(
    parameter int SYMBOL_W  = 8,
    parameter int CHANNEL_W = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SYMBOL_W-1:0]   in_data,
    input  logic [CHANNEL_W-1:0]  in_channel,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2*SYMBOL_W-1:0] out_data,
    output logic [CHANNEL_W-1:0]  out_channel,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_orphan,
    output logic [CHANNEL_W-1:0]  st_wr_address,
    output logic [SYMBOL_W+1:0]   st_wr_writedata,
    output logic                  st_wr_write,
    input  logic                  st_wr_waitrequest,
    output logic [CHANNEL_W-1:0]  st_rd_address,
    input  logic [SYMBOL_W+1:0]   st_rd_readdata
);

    // State word: {pending, held_sop, held_symbol}
    localparam int STATE_W = SYMBOL_W + 2;
    // FIFO entry: {data, channel, sop, eop, empty}
    localparam int ENTRY_W = 2*SYMBOL_W + CHANNEL_W + 3;

    logic                  accept_p0;
    logic                  clear_done;

    logic                  vld_p1;
    logic [SYMBOL_W-1:0]   data_p1;
    logic [CHANNEL_W-1:0]  chan_p1;
    logic                  sop_p1;
    logic                  eop_p1;

    logic                  pending_p1;
    logic                  held_sop_p1;
    logic [SYMBOL_W-1:0]   held_sym_p1;
    logic                  pair_p1;
    logic                  emit_p1;
    logic [ENTRY_W-1:0]    entry_p1;
    logic [STATE_W-1:0]    next_state_p1;

    logic [ENTRY_W-1:0]    fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            used;
    logic [1:0]            occupancy;
    logic                  push;
    logic                  pop;
    logic [ENTRY_W-1:0]    head;

    // ---- S0: issue the state read for the offered channel, accept the beat
    assign st_rd_address = in_channel;
    assign occupancy     = used + {1'b0, vld_p1};
    // The S1 beat may still land in the FIFO, so it is counted as occupied;
    // this keeps S1 stall-free and the FIFO from overflowing.
    assign in_ready      = clear_done && !st_wr_waitrequest && (occupancy < 2'd2);
    assign accept_p0     = in_valid && in_ready;

    // Remember that the state RAM has finished its post-reset clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_done <= 1'b0;
        end else if (!st_wr_waitrequest) begin
            clear_done <= 1'b1;
        end
    end

    // S1 valid: one accepted beat in flight, discarded by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept_p0;
        end
    end

    // S1 payload capture; qualified by vld_p1 so it needs no reset
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            data_p1 <= in_data;
            chan_p1 <= in_channel;
            sop_p1  <= in_sop;
            eop_p1  <= in_eop;
        end
    end

    // ---- S1: state for chan_p1 is on readdata (write-first RAM covers the
    //      back-to-back same-channel case, so no local forwarding is needed)
    // Merge the new symbol with the channel's stored half-word
    always_comb begin
        pending_p1    = st_rd_readdata[STATE_W-1];
        held_sop_p1   = st_rd_readdata[SYMBOL_W];
        held_sym_p1   = st_rd_readdata[SYMBOL_W-1:0];
        // A new sop while a symbol is held orphans that symbol
        pair_p1       = pending_p1 && !sop_p1;
        emit_p1       = vld_p1 && (pair_p1 || eop_p1);
        entry_p1      = {data_p1, {SYMBOL_W{1'b0}}, chan_p1, sop_p1, 1'b1, 1'b1};
        next_state_p1 = '0;
        if (pair_p1) begin
            entry_p1 = {held_sym_p1, data_p1, chan_p1, held_sop_p1, eop_p1, 1'b0};
        end else if (!eop_p1) begin
            next_state_p1 = {1'b1, sop_p1, data_p1};
        end
    end

    assign err_orphan      = vld_p1 && pending_p1 && sop_p1;
    assign st_wr_write     = vld_p1;
    assign st_wr_address   = chan_p1;
    assign st_wr_writedata = next_state_p1;

    // ---- Output FIFO (2 entries), head drives the sink
    assign push      = emit_p1;
    assign out_valid = (used != 2'd0);
    assign pop       = out_valid && out_ready;
    assign head      = fifo_mem[rd_ptr];
    assign {out_data, out_channel, out_sop, out_eop, out_empty} = out_valid ? head : '0;

    // FIFO pointers and fill level; reset empties the FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            used   <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            used <= used + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= entry_p1;
        end
    end

endmodule
